fret_input_judge: RTL and testbench

FRET_INPUT_JUDGE -- requirements
Module: fret_input_judge

---
 rtl/guitar_hero_pkg.sv | 25 ++
 rtl/fret_debouncer.sv | 43 ++++
 rtl/fret_input_judge.sv | 140 ++++++++++++++
 tb/tb_fret_input_judge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_hero_pkg.sv
// Shared guitar_hero constants: lane geometry, hit window,
// scoring and game FSM encodings used by judge, display and notes.
package guitar_hero_pkg;

    localparam int LANES = 3;
    localparam int ROW_W = 10;

    localparam int HIT_TOP_ROW = 364;
    localparam int HIT_BOT_ROW = 400;

    localparam logic [4:0] SCORE_HIT   = 5'd10;
    localparam logic [4:0] SCORE_BONUS = 5'd20;
    localparam logic [7:0] COMBO_BONUS_MIN = 8'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    function automatic logic [1:0] count3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/fret_debouncer.sv
// One fret lane: 2-flop synchronizer, stable-count debouncer,
// and a one-cycle pulse on each debounced press.
module fret_debouncer #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                // Nth consecutive differing sample: accept new level
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fret_input_judge.sv
// Fret input judge: debounces buttons, grades presses against the
// hit window, tracks score/combo/misses and runs the game FSM.
import guitar_hero_pkg::*;

module fret_input_judge #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIT_TOP         = HIT_TOP_ROW,
    parameter int HIT_BOT         = HIT_BOT_ROW,
    parameter int MAX_MISS        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  btn,
    input  logic [2:0]  note_active,
    input  logic [29:0] note_y,
    output logic [2:0]  consume,
    output logic [2:0]  hit_pulse,
    output logic [2:0]  miss_pulse,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic        game_over
);

    localparam logic [9:0] TOP_Y = 10'(HIT_TOP);
    localparam logic [9:0] BOT_Y = 10'(HIT_BOT);

    game_state_t state_q;
    game_state_t state_d;
    logic        clear;
    logic        play;

    logic [LANES-1:0] press;
    logic [LANES-1:0] hit;
    logic [LANES-1:0] miss;
    logic [LANES-1:0] pass;
    logic [LANES-1:0] judged_q;
    logic [LANES-1:0] judged_d;

    logic [15:0] miss_cnt_q;
    logic [16:0] miss_sum;
    logic [1:0]  n_hit;
    logic [1:0]  n_miss;
    logic [4:0]  step;
    logic [17:0] score_sum;
    logic [8:0]  combo_sum;
    logic [15:0] score_d;
    logic [7:0]  combo_d;

    assign play = (state_q == ST_PLAY);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [9:0] y;
        logic       free;

        fret_debouncer #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .press(press[i])
        );

        assign y       = note_y[ROW_W*i +: ROW_W];
        assign free    = note_active[i] & ~judged_q[i];
        assign pass[i] = play & free & (y > BOT_Y);
        assign hit[i]  = play & press[i] & free
                       & (y >= TOP_Y) & (y <= BOT_Y);
        assign miss[i] = (play & press[i] & ~hit[i]) | pass[i];
    end

    // A lane with no note forgets its judged flag
    assign judged_d = (clear ? '0 : (judged_q | hit | pass))
                    & note_active;

    always_comb begin
        n_hit     = count3(hit);
        n_miss    = count3(miss);
        step      = (combo >= COMBO_BONUS_MIN) ? SCORE_BONUS : SCORE_HIT;
        score_sum = {2'b00, score} + 18'(n_hit) * 18'(step);
        score_d   = (score_sum > 18'd65535) ? 16'hffff : score_sum[15:0];
        combo_sum = {1'b0, combo} + 9'(n_hit);
        combo_d   = (combo_sum > 9'd255) ? 8'hff : combo_sum[7:0];
        if (|miss) begin
            combo_d = '0;
        end
        miss_sum  = {1'b0, miss_cnt_q} + 17'(n_miss);
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_PLAY;
                    clear   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (miss_sum >= 17'(MAX_MISS)) begin
                    state_d = ST_OVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            judged_q   <= '0;
            miss_cnt_q <= '0;
            consume    <= '0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            score      <= '0;
            combo      <= '0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            judged_q   <= judged_d;
            consume    <= hit;
            hit_pulse  <= hit;
            miss_pulse <= miss;
            game_over  <= (state_d == ST_OVER);
            if (clear) begin
                score      <= '0;
                combo      <= '0;
                miss_cnt_q <= '0;
            end else if (play) begin
                score      <= score_d;
                combo      <= combo_d;
                miss_cnt_q <= miss_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_fret_input_judge.sv
// Bench for fret_input_judge: directed table, corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_fret_input_judge;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  btn;
    logic [2:0]  note_active;
    logic [29:0] note_y;
    logic [2:0]  consume;
    logic [2:0]  hit_pulse;
    logic [2:0]  miss_pulse;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        game_over;

    always #5 clk = ~clk;

    fret_input_judge #(
        .DEBOUNCE_CYCLES(N),
        .HIT_TOP        (364),
        .HIT_BOT        (400),
        .MAX_MISS       (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .btn        (btn),
        .note_active(note_active),
        .note_y     (note_y),
        .consume    (consume),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .combo      (combo),
        .game_over  (game_over)
    );

    int passed = 0;
    int total  = 0;
    int hit_seen[3];
    int miss_seen[3];
    int cons_seen[3];
    int both_seen;

    // Behavioural model state
    int m_s1[3], m_s2[3], m_db[3], m_run[3], m_pr[3], m_jud[3];
    int m_state;
    int m_score, m_combo, m_miss;
    logic [2:0] e_hit, e_miss;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int l = 0; l < 3; l++) begin
            m_s1[l] = 0; m_s2[l] = 0; m_db[l] = 0;
            m_run[l] = 0; m_pr[l] = 0; m_jud[l] = 0;
        end
        m_state = 0; m_score = 0; m_combo = 0; m_miss = 0;
        e_hit = '0; e_miss = '0;
    endtask

    task automatic model_step();
        int nh, nm, inc, y;
        bit act, free;
        e_hit = '0;
        e_miss = '0;
        if (m_state == 1) begin
            for (int l = 0; l < 3; l++) begin
                y = int'(note_y[l*10 +: 10]);
                act = note_active[l];
                free = act && (m_jud[l] == 0);
                if (m_pr[l] != 0) begin
                    if (free && y >= 364 && y <= 400) e_hit[l] = 1'b1;
                    else e_miss[l] = 1'b1;
                end
                if (free && y > 400) begin
                    e_miss[l] = 1'b1;
                    m_jud[l] = 1;
                end
                if (e_hit[l]) m_jud[l] = 1;
            end
            nh = $countones(e_hit);
            nm = $countones(e_miss);
            inc = (m_combo >= 10) ? 20 : 10;
            m_score = m_score + nh * inc;
            if (m_score > 65535) m_score = 65535;
            if (nm > 0) m_combo = 0;
            else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
            m_miss += nm;
            if (m_miss >= 10) m_state = 2;
        end else if (start) begin
            m_state = 1;
            m_score = 0; m_combo = 0; m_miss = 0;
            for (int l = 0; l < 3; l++) m_jud[l] = 0;
        end
        for (int l = 0; l < 3; l++) begin
            if (!note_active[l]) m_jud[l] = 0;
            m_pr[l] = 0;
            m_run[l] = (m_s2[l] != m_db[l]) ? m_run[l] + 1 : 0;
            if (m_run[l] == N) begin
                m_db[l] = m_s2[l];
                m_run[l] = 0;
                m_pr[l] = m_db[l];
            end
            m_s2[l] = m_s1[l];
            m_s1[l] = int'(btn[l]);
        end
    endtask

    task automatic cmp_model();
        logic [33:0] act, exp;
        act = {consume, hit_pulse, miss_pulse, score, combo, game_over};
        exp = {e_hit, e_hit, e_miss, 16'(m_score), 8'(m_combo),
               (m_state == 2)};
        total++;
        if (act === exp) passed++;
        else $display("FAIL model t=%0t: got %h, expected %h",
                      $time, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        cmp_model();
        for (int l = 0; l < 3; l++) begin
            hit_seen[l]  += int'(hit_pulse[l]);
            miss_seen[l] += int'(miss_pulse[l]);
            cons_seen[l] += int'(consume[l]);
        end
        if (hit_pulse == 3'b011) both_seen++;
    endtask

    task automatic clear_seen();
        for (int l = 0; l < 3; l++) begin
            hit_seen[l] = 0; miss_seen[l] = 0; cons_seen[l] = 0;
        end
        both_seen = 0;
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        btn = btn | mask;
        repeat (hold) tick();
        btn = btn & ~mask;
        repeat (8) tick();
    endtask

    task automatic set_note(input int l, input int y, input bit a);
        note_y[l*10 +: 10] = 10'(y);
        note_active[l] = a;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int lane;
        int y;
        int exp_score;
        int exp_combo;
    } vec_t;

    vec_t vecs[11];

    initial begin
        for (int i = 0; i < 11; i++) begin
            vecs[i].lane = i % 3;
            vecs[i].y = (i == 0) ? 364 : (i == 1) ? 400 : 370 + i;
            vecs[i].exp_score = (i < 10) ? 10 * (i + 1) : 120;
            vecs[i].exp_combo = i + 1;
        end

        rst = 1'b1; start = 1'b0; btn = '0;
        note_active = '0; note_y = '0;
        model_reset();
        clear_seen();
        sync_reset();
        check("reset score", int'(score), 0);
        check("reset combo", int'(combo), 0);
        check("reset game_over", int'(game_over), 0);
        check("reset pulses", int'({consume, hit_pulse, miss_pulse}), 0);

        // Single hit in lane 0
        do_start();
        set_note(0, 380, 1'b1);
        clear_seen();
        press(3'b001, 10);
        check("hit0 count", hit_seen[0], 1);
        check("consume0 count", cons_seen[0], 1);
        check("hit score", int'(score), 10);
        check("hit combo", int'(combo), 1);
        set_note(0, 0, 1'b0);
        tick();

        // Glitch on lane 1 then a miss outside the window
        clear_seen();
        btn[1] = 1'b1;
        repeat (2) tick();
        btn[1] = 1'b0;
        repeat (8) tick();
        check("glitch miss1", miss_seen[1], 0);
        check("glitch hit1", hit_seen[1], 0);
        set_note(1, 200, 1'b1);
        clear_seen();
        press(3'b010, 10);
        check("early miss1", miss_seen[1], 1);
        check("early consume1", cons_seen[1], 0);
        check("early combo", int'(combo), 0);
        check("early score", int'(score), 10);
        set_note(1, 0, 1'b0);
        tick();

        // Pass-through miss on lane 2
        clear_seen();
        set_note(2, 399, 1'b1);
        tick();
        check("pass y399", int'(miss_pulse[2]), 0);
        set_note(2, 400, 1'b1);
        tick();
        check("pass y400", int'(miss_pulse[2]), 0);
        set_note(2, 401, 1'b1);
        tick();
        check("pass y401", int'(miss_pulse[2]), 1);
        set_note(2, 402, 1'b1);
        tick();
        tick();
        check("pass once", miss_seen[2], 1);
        set_note(2, 0, 1'b0);
        tick();

        // Fresh game: table of consecutive hits
        sync_reset();
        do_start();
        for (int i = 0; i < 11; i++) begin
            set_note(vecs[i].lane, 0, 1'b0);
            tick();
            set_note(vecs[i].lane, vecs[i].y, 1'b1);
            clear_seen();
            press(3'(1 << vecs[i].lane), 10);
            check($sformatf("vec%0d hit", i), hit_seen[vecs[i].lane], 1);
            check($sformatf("vec%0d miss", i), miss_seen[vecs[i].lane], 0);
            check($sformatf("vec%0d score", i), int'(score),
                  vecs[i].exp_score);
            check($sformatf("vec%0d combo", i), int'(combo),
                  vecs[i].exp_combo);
            set_note(vecs[i].lane, 0, 1'b0);
        end
        tick();

        // Lanes 0 and 1 hit together at bonus rate
        set_note(0, 380, 1'b1);
        set_note(1, 380, 1'b1);
        clear_seen();
        press(3'b011, 10);
        check("dual same cycle", both_seen, 1);
        check("dual score", int'(score), 160);
        check("dual combo", int'(combo), 13);
        set_note(0, 0, 1'b0);
        set_note(1, 0, 1'b0);
        tick();

        // Just above the window is a miss
        set_note(2, 363, 1'b1);
        clear_seen();
        press(3'b100, 10);
        check("y363 miss", miss_seen[2], 1);
        check("y363 combo", int'(combo), 0);
        set_note(2, 0, 1'b0);
        tick();

        // Nine more misses end the game
        for (int i = 0; i < 9; i++) press(3'b010, 10);
        check("over flag", int'(game_over), 1);
        check("over score", int'(score), 160);
        clear_seen();
        set_note(0, 380, 1'b1);
        press(3'b001, 10);
        check("over ignore hit", hit_seen[0], 0);
        check("over ignore miss", miss_seen[0], 0);
        check("over hold score", int'(score), 160);
        do_start();
        check("restart score", int'(score), 0);
        check("restart combo", int'(combo), 0);
        check("restart over", int'(game_over), 0);

        // Async reset mid-game and mid-debounce
        clear_seen();
        press(3'b001, 10);
        check("pre-rst score", int'(score), 10);
        btn[0] = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        cmp_model();
        check("async score", int'(score), 0);
        check("async combo", int'(combo), 0);
        check("async over", int'(game_over), 0);
        tick();
        rst = 1'b0;
        clear_seen();
        repeat (12) tick();
        check("idle ignore hit", hit_seen[0], 0);
        check("idle ignore miss", miss_seen[0], 0);
        btn[0] = 1'b0;
        repeat (8) tick();
        do_start();
        clear_seen();
        press(3'b001, 10);
        check("post-rst hit", hit_seen[0], 1);

        // Randomized traffic
        btn = '0;
        note_active = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 3; l++) begin
                if ($urandom_range(0, 7) == 0) btn[l] = ~btn[l];
                if ($urandom_range(0, 5) == 0)
                    note_active[l] = ~note_active[l];
                if ($urandom_range(0, 3) == 0)
                    note_y[l*10 +: 10] = 10'($urandom_range(340, 420));
            end
            start = ($urandom_range(0, 49) == 0);
            tick();
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
